pipeline_stall_ctrl: RTL and testbench
======================================

Name: pipeline_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline. It arbitrates three pipeline-control sources:
- load-use hazards (ID vs EX)
- taken branches / jumps resolved in EX
- multi-cycle data-memory accesses in MEM

It drives PC write, per-stage pipeline-register enables, the IF/ID flush and the ID/EX bubble select, and keeps a saturating stall-cycle counter for performance measurement.

Parameters:
MEM_LAT, 2, total data-memory access latency in cycles (legal: >= 1; 1 = single-cycle memory, no freeze)
CNT_W, 16, width of stall-cycle counter

Ports:
clk  in  1  system clock, rising edge
arst_n  in  1  asynchronous active-low reset
rs1_id  in  5  source register 1 of instruction in ID
rs2_id  in  5  source register 2 of instruction in ID
rd_ex  in  5  destination register of instruction in EX
mem_read_ex  in  1  instruction in EX is a load
branch_taken_ex  in  1  control transfer taken in EX (redirect PC)
mem_access_mem  in  1  instruction in MEM performs a load or store
pc_w  out  1  PC register write enable
if_id_en  out  1  IF/ID register enable
id_ex_en  out  1  ID/EX register enable
ex_mem_en  out  1  EX/MEM register enable
mem_wb_en  out  1  MEM/WB register enable
if_id_flush  out  1  load NOP into IF/ID
id_ex_bubble  out  1  select zeroed control into ID/EX
stall_cnt  out  CNT_W  number of cycles with pc_w=0, saturating

Behaviour:
Reset:
- arst_n=0 asynchronously sets: state=RUN, wait counter=0, stall_cnt=0.
- While arst_n=0: pc_w and all *_en are 0; if_id_flush and id_ex_bubble are 0.

FSM states: RUN, MEM_WAIT. Wait counter width: clog2(MEM_LAT) (min 1). All outputs are combinational from state + inputs.

Freeze (all stages hold):
- pc_w, if_id_en, id_ex_en, ex_mem_en, mem_wb_en = 0
- if_id_flush = 0, id_ex_bubble = 0

RUN:
- If mem_access_mem=1 and MEM_LAT>1: freeze, load counter with MEM_LAT-2, go to MEM_WAIT.
- Else, if branch_taken_ex=1: all enables 1, pc_w=1, if_id_flush=1, id_ex_bubble=1.
- Else, if load-use: pc_w=0, if_id_en=0, id_ex_bubble=1; id_ex_en, ex_mem_en, mem_wb_en = 1.
  - Load-use condition: mem_read_ex=1, rd_ex!=0, and (rd_ex==rs1_id or rd_ex==rs2_id).
- Else: normal flow; all enables 1, flush/bubble 0.

MEM_WAIT:
- Counter != 0: freeze, decrement counter.
- Counter == 0 (release cycle):
  - Ignore mem_access_mem. The same access is complete, so there is no re-trigger.
  - Evaluate branch / load-use / normal exactly as in RUN.
  - Next state is RUN.

Priority and corner cases:
- Priority: memory freeze > branch flush > load-use.
- Branch and load-use in the same cycle: branch wins; the dependent instruction is squashed, so there is no stall.
- Branch during a freeze: EX is held, so branch_taken_ex stays stable; it takes effect on the release cycle.
- Memory-access timing: an access completes after MEM_LAT-1 freeze cycles and is released on the MEM_LAT-th cycle after MEM entry.
- Back-to-back memory instructions: the next access enters MEM on the cycle after release, and RUN re-detects it.
- rd_ex=0 never causes a load-use stall.

stall_cnt:
- Increments on each rising clk where pc_w=0 (freeze or load-use).
- Holds at 2^CNT_W-1.

Reset mid-freeze: immediately returns to RUN; the counter and stall_cnt clear.

Test Plan:
- Reset: assert arst_n=0 mid-MEM_WAIT -> all enables 0 at once; after release, state RUN and stall_cnt=0; with idle inputs all enables 1 on the next cycle.
- Load-use: mem_read_ex=1, rd_ex=5, rs2_id=5 -> one cycle with pc_w=0, if_id_en=0, id_ex_bubble=1; stall_cnt increments to 1. Repeat with rd_ex=0, rs1_id=0 -> no stall.
- Memory freeze: MEM_LAT=3, one-cycle mem_access_mem pulse held by a frozen pipeline -> exactly 2 freeze cycles, then release with all enables 1; stall_cnt=2.
- Branch vs load-use: branch_taken_ex=1 together with a load-use match -> pc_w=1, if_id_flush=1, id_ex_bubble=1, no stall; stall_cnt unchanged.
- Branch under freeze: MEM_LAT=4, mem_access_mem and branch_taken_ex both held -> 3 freeze cycles with flush=0, then the release cycle shows if_id_flush=1, pc_w=1.
- Saturation and single-cycle memory: CNT_W=2, 5 load-use stalls -> stall_cnt=3. With MEM_LAT=1, mem_access_mem=1 -> never freezes.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Arbitrates memory freeze, branch flush and load-use stalls.
module pipeline_stall_ctrl #(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic [4:0]       rd_ex,
  input  logic             mem_read_ex,
  input  logic             branch_taken_ex,
  input  logic             mem_access_mem,
  output logic             pc_w,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WCW = ($clog2(MEM_LAT) > 0) ? $clog2(MEM_LAT) : 1;
  localparam int LOADV = (MEM_LAT > 1) ? MEM_LAT - 2 : 0;
  localparam logic [WCW-1:0] LOAD = LOADV[WCW-1:0];
  localparam bit MULTI = (MEM_LAT > 1);

  typedef enum logic {RUN, MEM_WAIT} state_e;

  state_e           state_q, state_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic [CNT_W-1:0] stall_q;

  logic load_use, mem_trig, hold;

  assign load_use = mem_read_ex && (rd_ex != 5'd0) &&
                    ((rd_ex == rs1_id) || (rd_ex == rs2_id));
  // The release cycle of MEM_WAIT never re-triggers on the same access
  assign mem_trig = MULTI && (state_q == RUN) && mem_access_mem;
  assign hold     = (state_q == MEM_WAIT) && (wcnt_q != '0);

  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    pc_w         = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (state_q == MEM_WAIT && wcnt_q == '0)
      state_d = RUN;
    priority case (1'b1)
      mem_trig, hold: begin
        pc_w      = 1'b0;
        if_id_en  = 1'b0;
        id_ex_en  = 1'b0;
        ex_mem_en = 1'b0;
        mem_wb_en = 1'b0;
        if (mem_trig) begin
          wcnt_d  = LOAD;
          state_d = MEM_WAIT;
        end else begin
          wcnt_d  = wcnt_q - 1'b1;
        end
      end
      branch_taken_ex: begin
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end
      load_use: begin
        pc_w         = 1'b0;
        if_id_en     = 1'b0;
        id_ex_bubble = 1'b1;
      end
      default: ;
    endcase
    if (!arst_n) begin
      pc_w         = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= RUN;
      wcnt_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (!pc_w && stall_q != {CNT_W{1'b1}})
        stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl across three
// parameterisations sharing one stimulus bus.
module tb_pipeline_stall_ctrl;

  localparam logic [6:0] RUNV = 7'b1111100;
  localparam logic [6:0] FRZ  = 7'b0000000;
  localparam logic [6:0] BR   = 7'b1111111;
  localparam logic [6:0] LU   = 7'b0011101;

  typedef struct {
    logic [6:0]  ctl;
    logic [15:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic [4:0] rs1_id = '0, rs2_id = '0, rd_ex = '0;
  logic       mem_read_ex = 1'b0;
  logic       branch_taken_ex = 1'b0;
  logic       mem_access_mem = 1'b0;

  logic [6:0]  ctl_a, ctl_b, ctl_c;
  logic [15:0] cnt_a, cnt_b;
  logic [1:0]  cnt_c;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl #(.MEM_LAT(3), .CNT_W(16)) u_a (
    .clk(clk), .arst_n(arst_n),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_ex(rd_ex),
    .mem_read_ex(mem_read_ex),
    .branch_taken_ex(branch_taken_ex),
    .mem_access_mem(mem_access_mem),
    .pc_w(ctl_a[6]), .if_id_en(ctl_a[5]),
    .id_ex_en(ctl_a[4]), .ex_mem_en(ctl_a[3]),
    .mem_wb_en(ctl_a[2]), .if_id_flush(ctl_a[1]),
    .id_ex_bubble(ctl_a[0]), .stall_cnt(cnt_a)
  );

  pipeline_stall_ctrl #(.MEM_LAT(4), .CNT_W(16)) u_b (
    .clk(clk), .arst_n(arst_n),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_ex(rd_ex),
    .mem_read_ex(mem_read_ex),
    .branch_taken_ex(branch_taken_ex),
    .mem_access_mem(mem_access_mem),
    .pc_w(ctl_b[6]), .if_id_en(ctl_b[5]),
    .id_ex_en(ctl_b[4]), .ex_mem_en(ctl_b[3]),
    .mem_wb_en(ctl_b[2]), .if_id_flush(ctl_b[1]),
    .id_ex_bubble(ctl_b[0]), .stall_cnt(cnt_b)
  );

  pipeline_stall_ctrl #(.MEM_LAT(1), .CNT_W(2)) u_c (
    .clk(clk), .arst_n(arst_n),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_ex(rd_ex),
    .mem_read_ex(mem_read_ex),
    .branch_taken_ex(branch_taken_ex),
    .mem_access_mem(mem_access_mem),
    .pc_w(ctl_c[6]), .if_id_en(ctl_c[5]),
    .id_ex_en(ctl_c[4]), .ex_mem_en(ctl_c[3]),
    .mem_wb_en(ctl_c[2]), .if_id_flush(ctl_c[1]),
    .id_ex_bubble(ctl_c[0]), .stall_cnt(cnt_c)
  );

  task automatic drive(input logic mr, input logic [4:0] rd,
                       input logic [4:0] r1, input logic [4:0] r2,
                       input logic br, input logic ma);
    @(negedge clk);
    mem_read_ex     = mr;
    rd_ex           = rd;
    rs1_id          = r1;
    rs2_id          = r2;
    branch_taken_ex = br;
    mem_access_mem  = ma;
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst_n = 1'b0;
    mem_read_ex = 0; rd_ex = 0; rs1_id = 0; rs2_id = 0;
    branch_taken_ex = 0; mem_access_mem = 0;
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    #1;
    exp_q.push_back('{FRZ, 16'd0});
    e = exp_q.pop_front();
    n_tests++;
    if ({ctl_a, ctl_b, ctl_c} !== {e.ctl, e.ctl, e.ctl} ||
        cnt_a !== e.cnt || cnt_b !== e.cnt || cnt_c !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_init: got %b/%b/%b want %b",
               ctl_a, ctl_b, ctl_c, e.ctl);
    end
    do_reset();
    drive(0, 0, 0, 0, 0, 1);
    exp_q.push_back('{FRZ, 16'd0});
    #1; e = exp_q.pop_front(); n_tests++;
    if (ctl_a !== e.ctl || cnt_a !== e.cnt) begin
      n_fail++;
      $display("FAIL reset_enter_wait: got ctl=%b cnt=%0d want ctl=%b cnt=%0d",
               ctl_a, cnt_a, e.ctl, e.cnt);
    end
    @(negedge clk);
    mem_access_mem = 1'b0;
    arst_n = 1'b0;
    exp_q.push_back('{FRZ, 16'd0});
    #1; e = exp_q.pop_front(); n_tests++;
    if (ctl_a !== e.ctl || cnt_a !== e.cnt) begin
      n_fail++;
      $display("FAIL reset_mid_freeze: got ctl=%b cnt=%0d want ctl=%b cnt=%0d",
               ctl_a, cnt_a, e.ctl, e.cnt);
    end
    @(negedge clk);
    arst_n = 1'b1;
    exp_q.push_back('{RUNV, 16'd0});
    #1; e = exp_q.pop_front(); n_tests++;
    if (ctl_a !== e.ctl || cnt_a !== e.cnt) begin
      n_fail++;
      $display("FAIL reset_release: got ctl=%b cnt=%0d want ctl=%b cnt=%0d",
               ctl_a, cnt_a, e.ctl, e.cnt);
    end
    drive(0, 0, 0, 0, 0, 1);
    exp_q.push_back('{FRZ, 16'd0});
    #1; e = exp_q.pop_front(); n_tests++;
    if (ctl_a !== e.ctl || cnt_a !== e.cnt) begin
      n_fail++;
      $display("FAIL reset_state_run: got ctl=%b cnt=%0d want ctl=%b cnt=%0d",
               ctl_a, cnt_a, e.ctl, e.cnt);
    end
  endtask

  task automatic test_load_use();
    logic       mr [6] = '{1, 0, 1, 1, 1, 0};
    logic [4:0] rd [6] = '{5, 0, 0, 7, 7, 7};
    logic [4:0] r1 [6] = '{3, 0, 0, 7, 1, 7};
    logic [4:0] r2 [6] = '{5, 0, 0, 2, 2, 7};
    logic [6:0] ec [6] = '{LU, RUNV, RUNV, LU, RUNV, RUNV};
    int         cc [6] = '{0, 1, 1, 1, 2, 2};
    exp_t e;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(mr[i], rd[i], r1[i], r2[i], 0, 0);
      exp_q.push_back('{ec[i], 16'(cc[i])});
      #1; e = exp_q.pop_front(); n_tests++;
      if (ctl_a !== e.ctl || cnt_a !== e.cnt) begin
        n_fail++;
        $display("FAIL load_use[%0d]: got ctl=%b cnt=%0d want ctl=%b cnt=%0d",
                 i, ctl_a, cnt_a, e.ctl, e.cnt);
      end
    end
  endtask

  task automatic test_mem_freeze();
    logic       ma [4] = '{1, 0, 0, 0};
    logic [6:0] ec [4] = '{FRZ, FRZ, RUNV, RUNV};
    int         cc [4] = '{0, 1, 2, 2};
    exp_t e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, ma[i]);
      exp_q.push_back('{ec[i], 16'(cc[i])});
      #1; e = exp_q.pop_front(); n_tests++;
      if (ctl_a !== e.ctl || cnt_a !== e.cnt) begin
        n_fail++;
        $display("FAIL mem_freeze[%0d]: got ctl=%b cnt=%0d want ctl=%b cnt=%0d",
                 i, ctl_a, cnt_a, e.ctl, e.cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic       ma [6] = '{1, 1, 1, 1, 1, 0};
    logic [6:0] ec [6] = '{FRZ, FRZ, RUNV, FRZ, FRZ, RUNV};
    int         cc [6] = '{0, 1, 2, 2, 3, 4};
    exp_t e;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 0, 0, ma[i]);
      exp_q.push_back('{ec[i], 16'(cc[i])});
      #1; e = exp_q.pop_front(); n_tests++;
      if (ctl_a !== e.ctl || cnt_a !== e.cnt) begin
        n_fail++;
        $display("FAIL back_to_back[%0d]: got ctl=%b cnt=%0d want ctl=%b cnt=%0d",
                 i, ctl_a, cnt_a, e.ctl, e.cnt);
      end
    end
  endtask

  task automatic test_branch_vs_lu();
    logic       br [3] = '{1, 1, 0};
    logic [6:0] ec [3] = '{BR, BR, RUNV};
    exp_t e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(br[i], 5'd5, 5'd5, 5'd5, br[i], 0);
      exp_q.push_back('{ec[i], 16'd0});
      #1; e = exp_q.pop_front(); n_tests++;
      if (ctl_a !== e.ctl || cnt_a !== e.cnt) begin
        n_fail++;
        $display("FAIL branch_vs_lu[%0d]: got ctl=%b cnt=%0d want ctl=%b cnt=%0d",
                 i, ctl_a, cnt_a, e.ctl, e.cnt);
      end
    end
  endtask

  task automatic test_branch_freeze();
    logic       hv [5] = '{1, 1, 1, 1, 0};
    logic [6:0] ec [5] = '{FRZ, FRZ, FRZ, BR, RUNV};
    int         cc [5] = '{0, 1, 2, 3, 3};
    exp_t e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, hv[i], hv[i]);
      exp_q.push_back('{ec[i], 16'(cc[i])});
      #1; e = exp_q.pop_front(); n_tests++;
      if (ctl_b !== e.ctl || cnt_b !== e.cnt) begin
        n_fail++;
        $display("FAIL branch_freeze[%0d]: got ctl=%b cnt=%0d want ctl=%b cnt=%0d",
                 i, ctl_b, cnt_b, e.ctl, e.cnt);
      end
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      if (i < 5) begin
        drive(1, 5'd9, 5'd9, 5'd0, 0, 0);
        exp_q.push_back('{LU, 16'((i < 3) ? i : 3)});
      end else begin
        drive(0, 0, 0, 0, 0, (i > 5));
        exp_q.push_back('{RUNV, 16'd3});
      end
      #1; e = exp_q.pop_front(); n_tests++;
      if (ctl_c !== e.ctl || {14'd0, cnt_c} !== e.cnt) begin
        n_fail++;
        $display("FAIL saturation[%0d]: got ctl=%b cnt=%0d want ctl=%b cnt=%0d",
                 i, ctl_c, cnt_c, e.ctl, e.cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mem_freeze();
    test_back_to_back();
    test_branch_vs_lu();
    test_branch_freeze();
    test_saturation();
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
